// File: rtl/rv32i_decode_exec.sv
// rtl/rv32i_decode_exec.sv - RV32I main/ALU-control decode, 32-bit ALU and branch resolve, one register stage
//
// Purpose: decodes the fetched instruction into datapath control strobes,
// selects and evaluates the ALU operation on the supplied operands, resolves
// conditional branches, and registers everything for the following stage.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   instruction           32-bit instruction word
//   rs1_data, rs2_data    register-file read data
//   eximm                 sign-extended immediate
//   alu_op, reg_src       ALU operation class; writeback source select
//   alu_src               1 = op2 is eximm, 0 = op2 is rs2_data
//   reg_write, mem_read, mem_write, branch, jump   control strobes
//   field                 ALU function code
//   result                ALU result
//   zero, sign, overflow, carry   ALU flags
//   branch_taken          conditional branch resolved taken
module rv32i_decode_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] eximm,
  output logic [1:0]  alu_op,
  output logic [1:0]  reg_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
  output logic [3:0]  field,
  output logic [31:0] result,
  output logic        zero,
  output logic        sign,
  output logic        overflow,
  output logic        carry,
  output logic        branch_taken
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLL  = 4'd2;
  localparam logic [3:0] F_SLT  = 4'd3;
  localparam logic [3:0] F_SLTU = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_OR   = 4'd8;
  localparam logic [3:0] F_AND  = 4'd9;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instruction[6:0];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];

  // Instruction bits that carry register indices or immediates are consumed
  // elsewhere in the core, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // Next-state (combinational) values
  logic [1:0]  alu_op_d, reg_src_d;
  logic        alu_src_d, reg_write_d, mem_read_d, mem_write_d, branch_d, jump_d;
  logic        is_lui;
  logic [3:0]  field_d;
  logic [31:0] result_d;
  logic        zero_d, sign_d, overflow_d, carry_d, branch_taken_d;

  // Registered values
  logic [1:0]  alu_op_q, reg_src_q;
  logic        alu_src_q, reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q;
  logic [3:0]  field_q;
  logic [31:0] result_q;
  logic        zero_q, sign_q, overflow_q, carry_q, branch_taken_q;

  // Main control decode
  always_comb begin
    alu_op_d    = 2'b00;
    reg_src_d   = 2'd0;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    is_lui      = 1'b0;
    unique case (opcode)
      OP_R: begin
        alu_op_d    = 2'b10;
        reg_write_d = 1'b1;
      end
      OP_I: begin
        alu_op_d    = 2'b11;
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      OP_LOAD: begin
        alu_src_d   = 1'b1;
        reg_src_d   = 2'd1;
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
      end
      OP_STORE: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_BR: begin
        alu_op_d = 2'b01;
        branch_d = 1'b1;
      end
      OP_JAL: begin
        reg_src_d   = 2'd3;
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
      end
      OP_JALR: begin
        alu_src_d   = 1'b1;
        reg_src_d   = 2'd3;
        reg_write_d = 1'b1;
        jump_d      = 1'b1;
      end
      OP_LUI: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        is_lui      = 1'b1;
      end
      OP_AUIPC: begin
        alu_src_d   = 1'b1;
        reg_src_d   = 2'd2;
        reg_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU-control decode; the immediate form (alu_op 11) has no subtract
  always_comb begin
    field_d = F_ADD;
    case (alu_op_d)
      2'b00: field_d = F_ADD;
      2'b01: field_d = F_SUB;
      default: begin
        case (funct3)
          3'b000: field_d = (funct7_b5 && alu_op_d == 2'b10) ? F_SUB : F_ADD;
          3'b001: field_d = F_SLL;
          3'b010: field_d = F_SLT;
          3'b011: field_d = F_SLTU;
          3'b100: field_d = F_XOR;
          3'b101: field_d = funct7_b5 ? F_SRA : F_SRL;
          3'b110: field_d = F_OR;
          default: field_d = F_AND;
        endcase
      end
    endcase
  end

  // Operands and arithmetic
  logic [31:0] op1, op2, op2_eff;
  logic [4:0]  shamt;
  logic        is_sub;
  logic [32:0] sum33;

  assign op1     = is_lui ? 32'd0 : rs1_data;
  assign op2     = alu_src_d ? eximm : rs2_data;
  assign shamt   = op2[4:0];
  assign is_sub  = (field_d == F_SUB);
  // Subtract as op1 + ~op2 + 1 so bit 32 is the inverted borrow
  assign op2_eff = is_sub ? ~op2 : op2;
  assign sum33   = {1'b0, op1} + {1'b0, op2_eff} + {32'd0, is_sub};

  always_comb begin
    result_d = 32'd0;
    case (field_d)
      F_ADD, F_SUB: result_d = sum33[31:0];
      F_SLL:  result_d = op1 << shamt;
      F_SLT:  result_d = {31'd0, $signed(op1) < $signed(op2)};
      F_SLTU: result_d = {31'd0, op1 < op2};
      F_XOR:  result_d = op1 ^ op2;
      F_SRL:  result_d = op1 >> shamt;
      F_SRA:  result_d = $unsigned($signed(op1) >>> shamt);
      F_OR:   result_d = op1 | op2;
      F_AND:  result_d = op1 & op2;
      default: result_d = 32'd0;
    endcase
  end

  always_comb begin
    zero_d     = (result_d == 32'd0);
    sign_d     = result_d[31];
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    if (field_d == F_ADD || field_d == F_SUB) begin
      carry_d    = sum33[32];
      // Same-sign addends producing an opposite-sign sum
      overflow_d = (op1[31] == op2_eff[31]) && (sum33[31] != op1[31]);
    end
  end

  // Branch condition from the flags of the op1 - op2 subtraction
  always_comb begin
    branch_taken_d = 1'b0;
    case (funct3)
      3'b000: branch_taken_d = zero_d;
      3'b001: branch_taken_d = !zero_d;
      3'b100: branch_taken_d = sign_d ^ overflow_d;
      3'b101: branch_taken_d = !(sign_d ^ overflow_d);
      3'b110: branch_taken_d = !carry_d;
      3'b111: branch_taken_d = carry_d;
      default: branch_taken_d = 1'b0;
    endcase
    branch_taken_d = branch_taken_d && branch_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op_q       <= 2'b00;
      reg_src_q      <= 2'd0;
      alu_src_q      <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      branch_q       <= 1'b0;
      jump_q         <= 1'b0;
      field_q        <= 4'd0;
      result_q       <= 32'd0;
      zero_q         <= 1'b0;
      sign_q         <= 1'b0;
      overflow_q     <= 1'b0;
      carry_q        <= 1'b0;
      branch_taken_q <= 1'b0;
    end else begin
      alu_op_q       <= alu_op_d;
      reg_src_q      <= reg_src_d;
      alu_src_q      <= alu_src_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      branch_q       <= branch_d;
      jump_q         <= jump_d;
      field_q        <= field_d;
      result_q       <= result_d;
      zero_q         <= zero_d;
      sign_q         <= sign_d;
      overflow_q     <= overflow_d;
      carry_q        <= carry_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign alu_op       = alu_op_q;
  assign reg_src      = reg_src_q;
  assign alu_src      = alu_src_q;
  assign reg_write    = reg_write_q;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign branch       = branch_q;
  assign jump         = jump_q;
  assign field        = field_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign sign         = sign_q;
  assign overflow     = overflow_q;
  assign carry        = carry_q;
  assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb/tb_rv32i_decode_exec.sv - self-checking bench for rv32i_decode_exec
module tb_rv32i_decode_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, rs1_data, rs2_data, eximm;
  logic [1:0]  alu_op, reg_src;
  logic        alu_src, reg_write, mem_read, mem_write, branch, jump;
  logic [3:0]  field;
  logic [31:0] result;
  logic        zero, sign, overflow, carry, branch_taken;

  int checks = 0;
  int errors = 0;

  rv32i_decode_exec dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .eximm(eximm),
    .alu_op(alu_op), .reg_src(reg_src), .alu_src(alu_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .field(field), .result(result),
    .zero(zero), .sign(sign), .overflow(overflow), .carry(carry),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  alu_op;
    logic [1:0]  reg_src;
    logic        alu_src;
    logic [4:0]  strobes;   // reg_write, mem_read, mem_write, branch, jump
    logic [3:0]  field;
    logic [31:0] result;
    logic [3:0]  flags;     // zero, sign, overflow, carry
    logic        taken;
  } exp_t;

  // Reference model: straight from the instruction-set rules.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
    exp_t e;
    string op;
    logic [31:0] a, b;
    logic [63:0] usum;
    longint ssum;
    logic [2:0] f3;
    logic cond;
    e = '0;
    f3 = ins[14:12];
    op = "add";
    a = r1;
    case (ins[6:0])
      7'b0110011: begin e.alu_op = 2; e.strobes = 5'b10000; end
      7'b0010011: begin e.alu_op = 3; e.alu_src = 1; e.strobes = 5'b10000; end
      7'b0000011: begin e.alu_src = 1; e.reg_src = 1; e.strobes = 5'b11000; end
      7'b0100011: begin e.alu_src = 1; e.strobes = 5'b00100; end
      7'b1100011: begin e.alu_op = 1; e.strobes = 5'b00010; end
      7'b1101111: begin e.reg_src = 3; e.strobes = 5'b10001; end
      7'b1100111: begin e.alu_src = 1; e.reg_src = 3; e.strobes = 5'b10001; end
      7'b0110111: begin e.alu_src = 1; e.strobes = 5'b10000; a = 0; end
      7'b0010111: begin e.alu_src = 1; e.reg_src = 2; e.strobes = 5'b10000; end
      default: ;
    endcase
    b = e.alu_src ? imm : r2;
    if (e.alu_op == 1) op = "sub";
    else if (e.alu_op >= 2) begin
      case (f3)
        0: op = (ins[30] && e.alu_op == 2) ? "sub" : "add";
        1: op = "sll";
        2: op = "slt";
        3: op = "sltu";
        4: op = "xor";
        5: op = ins[30] ? "sra" : "srl";
        6: op = "or";
        default: op = "and";
      endcase
    end
    case (op)
      "add": begin
        e.field = 0; e.result = a + b;
        usum = {32'd0, a} + {32'd0, b}; e.flags[0] = usum[32];
        ssum = longint'($signed(a)) + longint'($signed(b));
        e.flags[1] = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      "sub": begin
        e.field = 1; e.result = a - b;
        e.flags[0] = (a >= b);
        ssum = longint'($signed(a)) - longint'($signed(b));
        e.flags[1] = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      "sll":  begin e.field = 2; e.result = a << b[4:0]; end
      "slt":  begin e.field = 3; e.result = ($signed(a) < $signed(b)) ? 1 : 0; end
      "sltu": begin e.field = 4; e.result = (a < b) ? 1 : 0; end
      "xor":  begin e.field = 5; e.result = a ^ b; end
      "srl":  begin e.field = 6; e.result = a >> b[4:0]; end
      "sra":  begin e.field = 7; e.result = $unsigned($signed(a) >>> b[4:0]); end
      "or":   begin e.field = 8; e.result = a | b; end
      default: begin e.field = 9; e.result = a & b; end
    endcase
    e.flags[3] = (e.result == 0);
    e.flags[2] = e.result[31];
    cond = 0;
    case (f3)
      0: cond = (a == b);
      1: cond = (a != b);
      4: cond = ($signed(a) < $signed(b));
      5: cond = ($signed(a) >= $signed(b));
      6: cond = (a < b);
      7: cond = (a >= b);
      default: cond = 0;
    endcase
    e.taken = e.strobes[1] && cond;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.alu_op  = alu_op;
    o.reg_src = reg_src;
    o.alu_src = alu_src;
    o.strobes = {reg_write, mem_read, mem_write, branch, jump};
    o.field   = field;
    o.result  = result;
    o.flags   = {zero, sign, overflow, carry};
    o.taken   = branch_taken;
    return o;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag, exp_t e);
    exp_t o;
    o = observed();
    chk({tag, ".ctrl"}, 64'({o.alu_op, o.reg_src, o.alu_src, o.strobes}),
        64'({e.alu_op, e.reg_src, e.alu_src, e.strobes}));
    chk({tag, ".field"}, 64'(o.field), 64'(e.field));
    chk({tag, ".result"}, 64'(o.result), 64'(e.result));
    chk({tag, ".flags"}, 64'(o.flags), 64'(e.flags));
    chk({tag, ".taken"}, 64'(o.taken), 64'(e.taken));
  endtask

  // Drive one instruction, let it register, sample 1 time unit after the edge.
  task automatic step(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
    instruction = ins; rs1_data = r1; rs2_data = r2; eximm = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic run(string tag, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
    step(ins, r1, r2, imm);
    chk_model(tag, model(ins, r1, r2, imm));
  endtask

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  localparam logic [31:0] EDGES [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return EDGES[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ins, r1, r2, imm;
    logic [6:0]  opc;
    reset = 1'b1;
    instruction = 0; rs1_data = 0; rs2_data = 0; eximm = 0;
    #1;
    chk("reset_state", 64'(observed()), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD, then asynchronous reset while result 12 is held
    step(32'h002081B3, 5, 7, 0);
    chk("add.result", 64'(result), 64'd12);
    chk("add.field_aluop", 64'({field, alu_op}), 64'({4'd0, 2'b10}));
    chk("add.rw_src_zero", 64'({reg_write, reg_src, zero}), 64'({1'b1, 2'd0, 1'b0}));
    #2 reset = 1'b1;
    #1 chk("async_reset", 64'(observed()), 64'd0);
    @(posedge clk); #1;
    chk("reset_held", 64'(observed()), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_release", 64'(result), 64'd12);

    // SUB with signed overflow
    step(32'h402081B3, 32'h80000000, 1, 0);
    chk("sub.result", 64'(result), 64'h7FFFFFFF);
    chk("sub.field_ovf_carry_sign", 64'({field, overflow, carry, sign}), 64'({4'd1, 1'b1, 1'b1, 1'b0}));

    step(32'h00208463, 9, 9, 0);
    chk("beq", 64'({branch, alu_op, zero, branch_taken}), 64'({1'b1, 2'b01, 1'b1, 1'b1}));
    step(32'h0020E463, 1, 2, 0);
    chk("bltu_taken", 64'({carry, branch_taken}), 64'({1'b0, 1'b1}));
    step(32'h0020E463, 2, 1, 0);
    chk("bltu_not_taken", 64'(branch_taken), 64'd0);

    step(32'h4040D093, 32'hF0000000, 0, 32'h404);
    chk("srai", 64'({field, result, alu_src, sign}), 64'({4'd7, 32'hFF000000, 1'b1, 1'b1}));

    step(32'h00812083, 32'h100, 0, 8);
    chk("lw", 64'({result, mem_read, reg_src, reg_write}), 64'({32'h108, 1'b1, 2'd1, 1'b1}));

    step(32'h0000007F, 3, 4, 0);
    chk("unknown", 64'({reg_write, mem_read, mem_write, branch, jump, alu_op, branch_taken}), 64'd0);

    // LUI forces op1 to zero
    run("lui", 32'h123450B7, 32'hDEADBEEF, 0, 32'h12345000);

    // Randomised sweep against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do opc = 7'($urandom); while (opc inside {OPS});
      end else begin
        opc = OPS[$urandom_range(0, 8)];
      end
      ins = {$urandom} & 32'hFFFFFF80;
      ins = ins | {25'd0, opc};
      r1  = rand_operand();
      r2  = ($urandom_range(0, 3) == 0) ? r1 : rand_operand();
      imm = ($urandom_range(0, 1) == 0) ? {{20{ins[31]}}, ins[31:20]} : rand_operand();
      run($sformatf("rand%0d", i), ins, r1, r2, imm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
